// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle instruction sequencing FSM for the single-issue RISC-V core
module multicycle_control #(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  instOpcode,
    input  logic [2:0]  funct3,
    input  logic        isZero,
    input  logic        mem_ready,
    output logic [1:0]  ALUop,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_write,
    output logic [1:0]  pc_source,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic        trap,
    output logic [31:0] retired,
    output logic [3:0]  state_o
);

    localparam logic [3:0] S_RESET     = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXEC_R    = 4'd7;
    localparam logic [3:0] S_EXEC_I    = 4'd8;
    localparam logic [3:0] S_ALU_WB    = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_JAL       = 4'd11;
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

    logic [3:0]  state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [31:0] retired_q;
    logic        retire;
    logic        branch_legal;
    logic        branch_taken;

    assign branch_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign branch_taken = ((funct3 == 3'b000) && isZero) || ((funct3 == 3'b001) && !isZero);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        retire  = 1'b0;
        case (state_q)
            S_RESET: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_FETCH;
                    hold_d  = 4'd0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (instOpcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (instOpcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_ALU_WB, S_JAL: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                // Unsupported branch conditions trap rather than retire.
                if (branch_legal) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_comb begin
        ALUop      = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR, S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                ALUop     = 2'b10;
            end
            S_ALU_WB:   reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                ALUop     = 2'b01;
                pc_source = 2'b01;
                pc_write  = branch_taken;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
            end
            S_TRAP:     trap = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            hold_q    <= 4'd0;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (retire) retired_q <= retired_q + 32'd1;
        end
    end

    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  instOpcode = 7'h00;
    logic [2:0]  funct3 = 3'b000;
    logic        isZero = 1'b0;
    logic        mem_ready = 1'b1;
    logic [1:0]  ALUop;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_write;
    logic [1:0]  pc_source;
    logic        ir_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic        trap;
    logic [31:0] retired;
    logic [3:0]  state_o;

    multicycle_control #(.RESET_PC_HOLD(1)) dut (
        .clk(clk), .rst_n(rst_n), .instOpcode(instOpcode), .funct3(funct3),
        .isZero(isZero), .mem_ready(mem_ready), .ALUop(ALUop), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_write(pc_write), .pc_source(pc_source),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap),
        .retired(retired), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Control word: ALUop, src_a, src_b, pc_write, pc_source, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, trap
    localparam logic [16:0] C_ZERO      = 17'b00_0_00_0_00_0_0_0_0_0_00_0;
    localparam logic [16:0] C_FETCH_RDY = 17'b00_0_01_1_00_1_0_1_0_0_00_0;
    localparam logic [16:0] C_FETCH_WT  = 17'b00_0_01_0_00_0_0_1_0_0_00_0;
    localparam logic [16:0] C_DECODE    = 17'b00_0_11_0_00_0_0_0_0_0_00_0;
    localparam logic [16:0] C_MEM_ADDR  = 17'b00_1_10_0_00_0_0_0_0_0_00_0;
    localparam logic [16:0] C_MEM_READ  = 17'b00_0_00_0_00_0_1_1_0_0_00_0;
    localparam logic [16:0] C_MEM_WB    = 17'b00_0_00_0_00_0_0_0_0_1_01_0;
    localparam logic [16:0] C_MEM_WRITE = 17'b00_0_00_0_00_0_1_0_1_0_00_0;
    localparam logic [16:0] C_EXEC_R    = 17'b10_1_00_0_00_0_0_0_0_0_00_0;
    localparam logic [16:0] C_EXEC_I    = 17'b00_1_10_0_00_0_0_0_0_0_00_0;
    localparam logic [16:0] C_ALU_WB    = 17'b00_0_00_0_00_0_0_0_0_1_00_0;
    localparam logic [16:0] C_BR_TAKEN  = 17'b01_1_00_1_01_0_0_0_0_0_00_0;
    localparam logic [16:0] C_BR_NOT    = 17'b01_1_00_0_01_0_0_0_0_0_00_0;
    localparam logic [16:0] C_JAL       = 17'b00_0_00_1_10_0_0_0_0_1_10_0;
    localparam logic [16:0] C_TRAP      = 17'b00_0_00_0_00_0_0_0_0_0_00_1;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [16:0] act_ctl;
    assign act_ctl = {ALUop, alu_src_a, alu_src_b, pc_write, pc_source, ir_write,
                      iord, mem_read, mem_write, reg_write, mem_to_reg, trap};

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (state_o !== e.st || act_ctl !== e.ctl || retired !== e.ret) begin
                    n_bad++;
                    $display("FAIL %s: got state=%0d ctl=%b retired=%h, want state=%0d ctl=%b retired=%h",
                             e.name, state_o, act_ctl, retired, e.st, e.ctl, e.ret);
                end
            end
        end
    end

    task automatic push(input string nm, input logic [3:0] st, input logic [16:0] c, input logic [31:0] r);
        exp_t e;
        e.name = nm; e.st = st; e.ctl = c; e.ret = r;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        push("reset", 4'd0, C_ZERO, 32'd0);
        tick();
    endtask

    logic [2:0] br_f3 [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
    logic       br_z  [5] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
    logic       br_tk [5] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0};

    initial begin : stimulus
        tick();
        // add, then an illegal opcode that traps with retired held at 1
        do_reset();
        instOpcode = 7'h33;
        push("add_fetch", 4'd1, C_FETCH_RDY, 32'd0); tick();
        push("add_decode", 4'd2, C_DECODE, 32'd0);   tick();
        push("add_exec", 4'd7, C_EXEC_R, 32'd0);     tick();
        push("add_wb", 4'd9, C_ALU_WB, 32'd0);       tick();
        instOpcode = 7'h7F;
        push("add_done", 4'd1, C_FETCH_RDY, 32'd1);  tick();
        push("ill_decode", 4'd2, C_DECODE, 32'd1);   tick();
        for (int i = 0; i < 20; i++) begin
            push("ill_trap", 4'd15, C_TRAP, 32'd1);  tick();
        end
        rst_n = 1'b0;
        push("trap_async_rst", 4'd0, C_ZERO, 32'd0);
        tick();

        // addi with a two-cycle fetch stall
        do_reset();
        instOpcode = 7'h13;
        mem_ready  = 1'b0;
        push("addi_fetch_wait", 4'd1, C_FETCH_WT, 32'd0); tick();
        push("addi_fetch_wait", 4'd1, C_FETCH_WT, 32'd0); tick();
        mem_ready = 1'b1;
        push("addi_fetch", 4'd1, C_FETCH_RDY, 32'd0);     tick();
        push("addi_decode", 4'd2, C_DECODE, 32'd0);       tick();
        push("addi_exec", 4'd8, C_EXEC_I, 32'd0);         tick();
        push("addi_wb", 4'd9, C_ALU_WB, 32'd0);           tick();
        push("addi_done", 4'd1, C_FETCH_RDY, 32'd1);      tick();

        // lw with three wait cycles in MEM_READ
        do_reset();
        instOpcode = 7'h03;
        push("lw_fetch", 4'd1, C_FETCH_RDY, 32'd0);  tick();
        push("lw_decode", 4'd2, C_DECODE, 32'd0);    tick();
        push("lw_addr", 4'd3, C_MEM_ADDR, 32'd0);    tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            push("lw_read", 4'd4, C_MEM_READ, 32'd0); tick();
        end
        push("lw_wb", 4'd5, C_MEM_WB, 32'd0);        tick();
        push("lw_done", 4'd1, C_FETCH_RDY, 32'd1);   tick();

        // beq/bne taken and not taken, then an unsupported funct3
        for (int k = 0; k < 5; k++) begin
            do_reset();
            instOpcode = 7'h63;
            funct3     = br_f3[k];
            isZero     = br_z[k];
            push("br_fetch", 4'd1, C_FETCH_RDY, 32'd0); tick();
            push("br_decode", 4'd2, C_DECODE, 32'd0);   tick();
            push(k == 4 ? "br_bad_f3" : "br_exec", 4'd10, br_tk[k] ? C_BR_TAKEN : C_BR_NOT, 32'd0);
            tick();
            if (k == 4) push("br_trap", 4'd15, C_TRAP, 32'd0);
            else        push("br_done", 4'd1, C_FETCH_RDY, 32'd1);
            tick();
        end
        funct3 = 3'b000;
        isZero = 1'b0;

        // sw retires, a second sw is abandoned by reset during MEM_WRITE
        do_reset();
        instOpcode = 7'h23;
        push("sw_fetch", 4'd1, C_FETCH_RDY, 32'd0);  tick();
        push("sw_decode", 4'd2, C_DECODE, 32'd0);    tick();
        push("sw_addr", 4'd3, C_MEM_ADDR, 32'd0);    tick();
        push("sw_write", 4'd6, C_MEM_WRITE, 32'd0);  tick();
        push("sw_done", 4'd1, C_FETCH_RDY, 32'd1);   tick();
        push("sw2_decode", 4'd2, C_DECODE, 32'd1);   tick();
        mem_ready = 1'b0;
        push("sw2_addr", 4'd3, C_MEM_ADDR, 32'd1);   tick();
        push("sw2_write", 4'd6, C_MEM_WRITE, 32'd1); tick();
        rst_n = 1'b0;
        push("sw2_async_rst", 4'd0, C_ZERO, 32'd0);
        mem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        push("sw2_restart", 4'd0, C_ZERO, 32'd0);    tick();
        push("sw2_refetch", 4'd1, C_FETCH_RDY, 32'd0); tick();

        // jal with the retired counter preloaded to wrap
        do_reset();
        instOpcode = 7'h6F;
        push("jal_fetch", 4'd1, C_FETCH_RDY, 32'd0); tick();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        push("jal_decode", 4'd2, C_DECODE, 32'hFFFF_FFFF); tick();
        push("jal_exec", 4'd11, C_JAL, 32'hFFFF_FFFF);     tick();
        push("jal_wrap", 4'd1, C_FETCH_RDY, 32'd0);        tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
